// File: rtl/sirv_clint_nhart.sv
// sirv_clint_nhart: multi-hart core-local interruptor on a native ICB slave port.
// Holds a shared 64-bit mtime, per-hart msip bits and 64-bit mtimecmp registers,
// and drives per-hart timer and software interrupt lines.
//
// ICB handshake: a command moves on i_icb_cmd_valid & i_icb_cmd_ready. There is
// a single response slot, so cmd_ready is high whenever that slot is empty or is
// being drained this cycle (~rsp_valid | rsp_ready). The response is registered
// one cycle after accept and rsp_valid/rdata/err hold until rsp_valid & rsp_ready.
module sirv_clint_nhart #(
    parameter int HART_NUM        = 2,
    parameter int RTC_SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_icb_cmd_valid,
    output logic                i_icb_cmd_ready,
    input  logic [31:0]         i_icb_cmd_addr,
    input  logic                i_icb_cmd_read,
    input  logic [31:0]         i_icb_cmd_wdata,
    input  logic [3:0]          i_icb_cmd_wmask,
    output logic                i_icb_rsp_valid,
    input  logic                i_icb_rsp_ready,
    output logic [31:0]         i_icb_rsp_rdata,
    output logic                i_icb_rsp_err,
    output logic [HART_NUM-1:0] io_tiles_mtip,
    output logic [HART_NUM-1:0] io_tiles_msip,
    input  logic                io_rtcToggle
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP      = 16'h4000;
    localparam logic [15:0] OFF_CTL      = 16'hBFF0;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    logic [RTC_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       dly_q, dly_d;
    logic                       tick;
    logic [63:0]                mtime_q, mtime_d;
    logic [63:0]                mtimecmp_q [HART_NUM];
    logic [63:0]                mtimecmp_d [HART_NUM];
    logic [HART_NUM-1:0]        msip_q, msip_d;
    logic [HART_NUM-1:0]        mtip_q, mtip_d;
    logic                       mtime_en_q, mtime_en_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       err_q, err_d;

    logic                       accept;
    logic                       wr_en;
    logic [15:0]                off;
    logic                       hit;
    logic [31:0]                rd_val;
    logic                       sel_ctl, sel_mtime_lo, sel_mtime_hi;
    logic [HART_NUM-1:0]        sel_msip, sel_cmp_lo, sel_cmp_hi;
    logic                       unused_addr_hi;

    // Byte-granular merge of write data into an existing 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = mask[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

    assign i_icb_cmd_ready = ~rsp_valid_q | i_icb_rsp_ready;
    assign accept          = i_icb_cmd_valid & i_icb_cmd_ready;
    assign wr_en           = accept & ~i_icb_cmd_read & hit;
    assign off             = i_icb_cmd_addr[15:0];
    assign unused_addr_hi  = ^i_icb_cmd_addr[31:16];

    // RTC toggle: synchronizer chain plus one delay flop; either edge is a tick.
    always_comb begin
        sync_d = {sync_q[RTC_SYNC_STAGES-2:0], io_rtcToggle};
        dly_d  = sync_q[RTC_SYNC_STAGES-1];
    end
    assign tick = sync_q[RTC_SYNC_STAGES-1] ^ dly_q;

    // Address decode and read mux; every mapped offset is word aligned, so a
    // misaligned address can never match and falls out as an error.
    always_comb begin
        hit          = 1'b0;
        rd_val       = '0;
        sel_ctl      = 1'b0;
        sel_mtime_lo = 1'b0;
        sel_mtime_hi = 1'b0;
        sel_msip     = '0;
        sel_cmp_lo   = '0;
        sel_cmp_hi   = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            if (off == OFF_MSIP + 16'(4 * h)) begin
                hit         = 1'b1;
                sel_msip[h] = 1'b1;
                rd_val      = {31'd0, msip_q[h]};
            end
            if (off == OFF_CMP + 16'(8 * h)) begin
                hit           = 1'b1;
                sel_cmp_lo[h] = 1'b1;
                rd_val        = mtimecmp_q[h][31:0];
            end
            if (off == OFF_CMP + 16'(8 * h + 4)) begin
                hit           = 1'b1;
                sel_cmp_hi[h] = 1'b1;
                rd_val        = mtimecmp_q[h][63:32];
            end
        end
        if (off == OFF_CTL) begin
            hit     = 1'b1;
            sel_ctl = 1'b1;
            rd_val  = {31'd0, mtime_en_q};
        end
        if (off == OFF_MTIME_LO) begin
            hit          = 1'b1;
            sel_mtime_lo = 1'b1;
            rd_val       = mtime_q[31:0];
        end
        if (off == OFF_MTIME_HI) begin
            hit          = 1'b1;
            sel_mtime_hi = 1'b1;
            rd_val       = mtime_q[63:32];
        end
    end

    // Register next state: a bus write to mtime overrides the tick increment.
    always_comb begin
        mtime_d = mtime_q;
        if (tick && mtime_en_q) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_en && sel_mtime_lo) begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_icb_cmd_wdata, i_icb_cmd_wmask)};
        end
        if (wr_en && sel_mtime_hi) begin
            mtime_d = {merge_bytes(mtime_q[63:32], i_icb_cmd_wdata, i_icb_cmd_wmask), mtime_q[31:0]};
        end

        mtime_en_d = mtime_en_q;
        if (wr_en && sel_ctl && i_icb_cmd_wmask[0]) begin
            mtime_en_d = i_icb_cmd_wdata[0];
        end

        for (int h = 0; h < HART_NUM; h++) begin
            msip_d[h] = msip_q[h];
            if (wr_en && sel_msip[h] && i_icb_cmd_wmask[0]) begin
                msip_d[h] = i_icb_cmd_wdata[0];
            end
            mtimecmp_d[h] = mtimecmp_q[h];
            if (wr_en && sel_cmp_lo[h]) begin
                mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0], i_icb_cmd_wdata, i_icb_cmd_wmask);
            end
            if (wr_en && sel_cmp_hi[h]) begin
                mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], i_icb_cmd_wdata, i_icb_cmd_wmask);
            end
            mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    // Response slot: load on accept, clear on drain, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            err_d       = ~hit;
            rdata_d     = (i_icb_cmd_read && hit) ? rd_val : 32'd0;
        end else if (i_icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            dly_q       <= 1'b0;
            mtime_q     <= '0;
            msip_q      <= '0;
            mtip_q      <= '0;
            mtime_en_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            for (int h = 0; h < HART_NUM; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            sync_q      <= sync_d;
            dly_q       <= dly_d;
            mtime_q     <= mtime_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            mtime_en_q  <= mtime_en_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            for (int h = 0; h < HART_NUM; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign i_icb_rsp_valid = rsp_valid_q;
    assign i_icb_rsp_rdata = rdata_q;
    assign i_icb_rsp_err   = err_q;
    assign io_tiles_mtip   = mtip_q;
    assign io_tiles_msip   = msip_q;

endmodule

// File: tb/tb_sirv_clint_nhart.sv
// Bench for sirv_clint_nhart: table of bus vectors plus hand sequences for
// RTC ticks, mtime wrap/write races, backpressure, throughput and mid-flight reset.
module tb_sirv_clint_nhart;

    localparam int HN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_icb_cmd_valid;
    logic          i_icb_cmd_ready;
    logic [31:0]   i_icb_cmd_addr;
    logic          i_icb_cmd_read;
    logic [31:0]   i_icb_cmd_wdata;
    logic [3:0]    i_icb_cmd_wmask;
    logic          i_icb_rsp_valid;
    logic          i_icb_rsp_ready;
    logic [31:0]   i_icb_rsp_rdata;
    logic          i_icb_rsp_err;
    logic [HN-1:0] io_tiles_mtip;
    logic [HN-1:0] io_tiles_msip;
    logic          io_rtcToggle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int resp_cnt = 0;

    // Expected responses: {check_rdata, err, rdata}
    logic [33:0] exp_q[$];

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        care;
        logic        exp_err;
    } vec_t;

    vec_t tbl[21];

    sirv_clint_nhart #(.HART_NUM(HN), .RTC_SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (i_icb_cmd_valid),
        .i_icb_cmd_ready (i_icb_cmd_ready),
        .i_icb_cmd_addr  (i_icb_cmd_addr),
        .i_icb_cmd_read  (i_icb_cmd_read),
        .i_icb_cmd_wdata (i_icb_cmd_wdata),
        .i_icb_cmd_wmask (i_icb_cmd_wmask),
        .i_icb_rsp_valid (i_icb_rsp_valid),
        .i_icb_rsp_ready (i_icb_rsp_ready),
        .i_icb_rsp_rdata (i_icb_rsp_rdata),
        .i_icb_rsp_err   (i_icb_rsp_err),
        .io_tiles_mtip   (io_tiles_mtip),
        .io_tiles_msip   (io_tiles_msip),
        .io_rtcToggle    (io_rtcToggle)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expectation per response handshake
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && i_icb_rsp_valid && i_icb_rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%0h err=%0b expected no response",
                         i_icb_rsp_rdata, i_icb_rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (e[33]) check("rsp_rdata", 64'(i_icb_rsp_rdata), 64'(e[31:0]));
                check("rsp_err", 64'(i_icb_rsp_err), 64'(e[32]));
                resp_cnt++;
            end
        end
    end

    // Driver: called at a drive point (posedge+1), returns at the next drive point after accept
    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] er, input logic care,
                        input logic ee);
        int n = 0;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read  = rd;
        i_icb_cmd_addr  = a;
        i_icb_cmd_wdata = wd;
        i_icb_cmd_wmask = m;
        @(negedge clk);
        while (!i_icb_cmd_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!i_icb_cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=0 expected 1 within 20 cycles");
        end else begin
            exp_q.push_back({care, ee, er});
        end
        @(posedge clk);
        #1;
        i_icb_cmd_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] er);
        send(1'b1, a, 32'h0, 4'h0, er, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        send(1'b0, a, wd, m, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c0;
        int r0;

        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = '0;
        i_icb_cmd_read  = 1'b0;
        i_icb_cmd_wdata = '0;
        i_icb_cmd_wmask = '0;
        i_icb_rsp_ready = 1'b1;
        io_rtcToggle    = 1'b0;

        //            rd    addr           wdata          mask  exp_rdata      care  err
        tbl[0]  = '{1'b1, 32'h0000_BFF8, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_BFFC, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_4000, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_4004, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_400C, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_BFF0, 32'h0,         4'h0, 32'h1,         1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h0200_BFF0, 32'h0,         4'h0, 32'h1,         1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0008, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1};
        tbl[9]  = '{1'b1, 32'h0000_4010, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1};
        tbl[10] = '{1'b1, 32'h0000_4002, 32'h0,         4'h0, 32'h0,         1'b0, 1'b1};
        tbl[11] = '{1'b1, 32'h0000_BFF4, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1};
        tbl[12] = '{1'b0, 32'h0000_0008, 32'h1,         4'hF, 32'h0,         1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'h0000_4001, 32'h0,         4'hF, 32'h0,         1'b0, 1'b1};
        tbl[14] = '{1'b0, 32'h0000_0001, 32'h1,         4'hF, 32'h0,         1'b0, 1'b1};
        tbl[15] = '{1'b1, 32'h0000_4000, 32'h0,         4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};
        tbl[17] = '{1'b0, 32'h0000_4008, 32'h5,         4'hF, 32'h0,         1'b0, 1'b0};
        tbl[18] = '{1'b0, 32'h0000_400C, 32'h0,         4'hF, 32'h0,         1'b0, 1'b0};
        tbl[19] = '{1'b1, 32'h0000_4008, 32'h0,         4'h0, 32'h5,         1'b1, 1'b0};
        tbl[20] = '{1'b1, 32'h0000_400C, 32'h0,         4'h0, 32'h0,         1'b1, 1'b0};

        // Reset
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        check("reset_cmd_ready", 64'(i_icb_cmd_ready), 64'd1);
        check("reset_mtip", 64'(io_tiles_mtip), 64'd0);
        check("reset_msip", 64'(io_tiles_msip), 64'd0);
        step(1);

        // Reset-state readback, error decode, mtimecmp1 = 5 (back to back)
        for (int i = 0; i < 21; i++) begin
            send(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
                 tbl[i].exp_rdata, tbl[i].care, tbl[i].exp_err);
        end
        drain();

        // Four RTC toggles, then the fifth with exact mtip timing
        for (int t = 0; t < 4; t++) begin
            io_rtcToggle = ~io_rtcToggle;
            step(4);
        end
        @(negedge clk);
        check("mtip_at_mtime4", 64'(io_tiles_mtip), 64'd0);
        step(1);
        io_rtcToggle = ~io_rtcToggle;
        repeat (4) @(negedge clk);
        check("mtip_when_mtime_hits5", 64'(io_tiles_mtip), 64'd0);
        @(negedge clk);
        check("mtip_one_clk_later", 64'(io_tiles_mtip), 64'b10);
        step(1);
        rd(32'hBFF8, 32'h5);
        rd(32'hBFFC, 32'h0);
        drain();

        // msip byte-mask writes
        wr(32'h0000, 32'hFFFF_FFFF, 4'b0001);
        @(negedge clk);
        check("msip0_set", 64'(io_tiles_msip), 64'b01);
        step(1);
        rd(32'h0000, 32'h1);
        wr(32'h0000, 32'h0, 4'b0000);
        wr(32'h0000, 32'h0, 4'b1110);
        rd(32'h0000, 32'h1);
        wr(32'h0004, 32'h1, 4'b0001);
        drain();
        @(negedge clk);
        check("msip_both", 64'(io_tiles_msip), 64'b11);
        step(1);

        // mtime wrap across both halves
        wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        drain();
        io_rtcToggle = ~io_rtcToggle;
        step(5);
        rd(32'hBFF8, 32'h0);
        rd(32'hBFFC, 32'h0);
        wr(32'hBFFC, 32'h1234_5678, 4'hF);
        drain();

        // mtime lo write lands in the same cycle as a tick
        io_rtcToggle = ~io_rtcToggle;
        @(posedge clk);
        step(1);
        wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        drain();
        step(5);
        rd(32'hBFF8, 32'hFFFF_FFFF);
        rd(32'hBFFC, 32'h1234_5678);
        drain();

        // mtime_en = 0: ticks ignored, mtime still writable with masks
        wr(32'hBFF0, 32'h0, 4'b0001);
        rd(32'hBFF0, 32'h0);
        drain();
        for (int t = 0; t < 3; t++) begin
            io_rtcToggle = ~io_rtcToggle;
            step(4);
        end
        rd(32'hBFF8, 32'hFFFF_FFFF);
        rd(32'hBFFC, 32'h1234_5678);
        wr(32'hBFF8, 32'h0000_0010, 4'b0011);
        rd(32'hBFF8, 32'hFFFF_0010);
        wr(32'hBFF0, 32'h1, 4'b0001);
        drain();

        // Backpressure: response held for 3 cycles
        i_icb_rsp_ready = 1'b0;
        rd(32'h4008, 32'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(i_icb_rsp_valid), 64'd1);
            check("hold_cmd_ready", 64'(i_icb_cmd_ready), 64'd0);
            check("hold_rdata", 64'(i_icb_rsp_rdata), 64'h5);
            check("hold_err", 64'(i_icb_rsp_err), 64'd0);
        end
        step(1);
        i_icb_rsp_ready = 1'b1;
        drain();

        // Back-to-back reads: one per cycle
        c0 = cyc;
        r0 = resp_cnt;
        rd(32'h4000, 32'hFFFF_FFFF);
        rd(32'h4004, 32'hFFFF_FFFF);
        rd(32'hBFF0, 32'h1);
        rd(32'h0004, 32'h1);
        check("b2b_cycles", 64'(cyc - c0), 64'd4);
        @(negedge clk);
        #1;
        check("b2b_responses", 64'(resp_cnt - r0), 64'd4);
        step(1);
        drain();

        // Reset while a response is pending
        i_icb_rsp_ready = 1'b0;
        rd(32'h0000, 32'h1);
        rst_n = 1'b0;
        io_rtcToggle = 1'b0;
        step(1);
        @(negedge clk);
        check("midrst_rsp_valid", 64'(i_icb_rsp_valid), 64'd0);
        check("midrst_msip", 64'(io_tiles_msip), 64'd0);
        check("midrst_mtip", 64'(io_tiles_mtip), 64'd0);
        step(1);
        exp_q.delete();
        rst_n = 1'b1;
        i_icb_rsp_ready = 1'b1;
        rd(32'h0000, 32'h0);
        rd(32'h4008, 32'hFFFF_FFFF);
        rd(32'hBFF8, 32'h0);
        rd(32'hBFF0, 32'h1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
